spi_byte_master: RTL and testbench

SPI master controller that drives a single SPI slave peripheral (sck, active-low ss, mosi, miso) from a simple request/response interface on the system clock. One request produces one `LEN`-bit full-duplex frame: shift out `req_data`, capture `miso` into `resp_data`. It sits directly upstream of the SPI slave device models on the NPC peripheral bus and generates every sck edge and ss window they see.

---
 rtl/spi_byte_master_if.sv | 26 ++
 rtl/spi_byte_master.sv | 155 +++++++++++++++
 tb/tb_spi_byte_master.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_byte_master_if.sv
// Request/response and SPI pin bundle for spi_byte_master.
// master: the controller's view; slave: the view of whatever drives requests
// and models the SPI peripheral.
interface spi_byte_master_if #(
    parameter int LEN = 16
);
    logic           req_valid;
    logic           req_ready;
    logic [LEN-1:0] req_data;
    logic           resp_valid;
    logic [LEN-1:0] resp_data;
    logic           sck;
    logic           ss;
    logic           mosi;
    logic           miso;

    modport master (
        input  req_valid, req_data, miso,
        output req_ready, resp_valid, resp_data, sck, ss, mosi
    );

    modport slave (
        output req_valid, req_data, miso,
        input  req_ready, resp_valid, resp_data, sck, ss, mosi
    );
endinterface

// File: rtl/spi_byte_master.sv
// SPI master: one accepted request produces one LEN-bit full-duplex frame.
// sck idles low; the slave samples mosi on sck rise, the master samples miso
// and advances mosi on sck fall.
// Optional macro SPI_BYTE_MASTER_LSB_FIRST_EN selects LSB-first bit order
// (default MSB-first); cycle timing is identical in both builds.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | ready for a request; ss high, sck low, mosi high
// S_SETUP | ss low, first bit on mosi, sck held low for CLK_DIV cycles
// S_SHIFT | sck toggles every CLK_DIV cycles for LEN rise/fall pairs
// S_HOLD  | sck held low for CLK_DIV cycles before ss is released
// S_DONE  | one-cycle gap after resp_valid; not ready
module spi_byte_master #(
    parameter int CLK_DIV = 4,
    parameter int LEN     = 16
) (
    input  logic              i_clock,
    input  logic              i_reset,
    spi_byte_master_if.master io_spi
);
    localparam int DW = $clog2(CLK_DIV) + 1;
    localparam int BW = $clog2(LEN) + 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_DONE
    } state_t;

    state_t         r_state;
    state_t         w_state_next;
    logic [DW-1:0]  r_div;
    logic [BW-1:0]  r_bit;
    logic [LEN-1:0] r_tx;
    logic [LEN-1:0] r_rx;
    logic [LEN-1:0] r_resp_data;
    logic           r_sck;
    logic           r_ss;
    logic           r_mosi;
    logic           r_resp_valid;

    logic           w_accept;
    logic           w_div_tc;
    logic           w_fall;
    logic           w_last_fall;
    logic           w_first_bit;
    logic           w_next_bit;
    logic [LEN-1:0] w_tx_load;
    logic [LEN-1:0] w_tx_shift;
    logic [LEN-1:0] w_rx_next;

    assign w_accept    = (r_state == S_IDLE) && io_spi.req_valid;
    assign w_div_tc    = (r_div == DIV_LAST);
    assign w_fall      = (r_state == S_SHIFT) && w_div_tc && r_sck;
    assign w_last_fall = w_fall && (r_bit == BIT_LAST);

    // The tx shifter holds the bits not yet on mosi; the rx shifter fills so
    // that the first received bit ends at the same end the first tx bit came from.
`ifdef SPI_BYTE_MASTER_LSB_FIRST_EN
    assign w_first_bit = io_spi.req_data[0];
    assign w_tx_load   = io_spi.req_data >> 1;
    assign w_next_bit  = r_tx[0];
    assign w_tx_shift  = r_tx >> 1;
    assign w_rx_next   = (r_rx >> 1) | (LEN'(io_spi.miso) << (LEN - 1));
`else
    assign w_first_bit = io_spi.req_data[LEN-1];
    assign w_tx_load   = io_spi.req_data << 1;
    assign w_next_bit  = r_tx[LEN-1];
    assign w_tx_shift  = r_tx << 1;
    assign w_rx_next   = (r_rx << 1) | LEN'(io_spi.miso);
`endif

    // State register.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_state_next;
    end

    // Next-state decode.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept)    w_state_next = S_SETUP;
            S_SETUP: if (w_div_tc)    w_state_next = S_SHIFT;
            S_SHIFT: if (w_last_fall) w_state_next = S_HOLD;
            S_HOLD:  if (w_div_tc)    w_state_next = S_DONE;
            S_DONE:                   w_state_next = S_IDLE;
            default:                  w_state_next = S_IDLE;
        endcase
    end

    // Divider, bit counter, shifters and registered SPI/response outputs.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_div        <= '0;
            r_bit        <= '0;
            r_tx         <= '0;
            r_rx         <= '0;
            r_resp_data  <= '0;
            r_sck        <= 1'b0;
            r_ss         <= 1'b1;
            r_mosi       <= 1'b1;
            r_resp_valid <= 1'b0;
        end else begin
            r_resp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_div <= '0;
                    r_bit <= '0;
                    if (w_accept) begin
                        r_tx   <= w_tx_load;
                        r_rx   <= '0;
                        r_ss   <= 1'b0;
                        r_mosi <= w_first_bit;
                    end
                end
                S_SETUP: begin
                    r_div <= w_div_tc ? '0 : r_div + DW'(1);
                    if (w_div_tc) r_sck <= 1'b1;
                end
                S_SHIFT: begin
                    r_div <= w_div_tc ? '0 : r_div + DW'(1);
                    if (w_div_tc) r_sck <= ~r_sck;
                    if (w_fall) begin
                        r_bit  <= r_bit + BW'(1);
                        r_rx   <= w_rx_next;
                        r_tx   <= w_tx_shift;
                        r_mosi <= w_last_fall ? 1'b1 : w_next_bit;
                    end
                end
                S_HOLD: begin
                    r_div <= w_div_tc ? '0 : r_div + DW'(1);
                    if (w_div_tc) begin
                        r_ss         <= 1'b1;
                        r_resp_valid <= 1'b1;
                        r_resp_data  <= r_rx;
                    end
                end
                default: r_div <= '0;
            endcase
        end
    end

    assign io_spi.req_ready  = (r_state == S_IDLE);
    assign io_spi.resp_valid = r_resp_valid;
    assign io_spi.resp_data  = r_resp_data;
    assign io_spi.sck        = r_sck;
    assign io_spi.ss         = r_ss;
    assign io_spi.mosi       = r_mosi;
endmodule

// File: tb/tb_spi_byte_master.sv
// Scoreboard bench for spi_byte_master: the expected frame is queued at
// acceptance from a bit-level reference model; a negedge monitor pops and
// compares on every resp_valid. A second instance (CLK_DIV=1, LEN=8, miso=1)
// covers the fastest divider.
module tb_spi_byte_master;
    localparam int CD0 = 4;
    localparam int LEN0 = 16;
    localparam int CD1 = 1;
    localparam int LEN1 = 8;
    localparam int RESP_CYC0 = (2 * LEN0 + 1) * CD0 + 1;
    localparam int RESP_CYC1 = (2 * LEN1 + 1) * CD1 + 1;
    localparam int PERIOD0 = (2 * LEN0 + 1) * CD0 + 2;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    spi_byte_master_if #(.LEN(LEN0)) bus0 ();
    spi_byte_master_if #(.LEN(LEN1)) bus1 ();

    spi_byte_master #(.CLK_DIV(CD0), .LEN(LEN0)) u_dut0 (
        .i_clock(clock), .i_reset(reset), .io_spi(bus0)
    );
    spi_byte_master #(.CLK_DIV(CD1), .LEN(LEN1)) u_dut1 (
        .i_clock(clock), .i_reset(reset), .io_spi(bus1)
    );

    typedef struct {
        logic [LEN0-1:0] data;
        int              acc;
    } exp_t;

    exp_t            exp_q[$];
    int              n_cmp = 0;
    int              n_bad = 0;
    int              cyc = 0;
    int              n_resp = 0;
    int              rise_cnt = 0;
    int              mode = 0;
    logic [LEN0-1:0] plan = '0;
    logic            miso_drv = 1'b0;
    logic [7:0]      slave_byte = '0;
    logic            first_bit_exp = 1'b0;
    logic            started = 1'b0;

    assign bus0.miso = (mode == 0) ? bus0.mosi : miso_drv;
    assign bus1.miso = 1'b1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // Reference model: bit k of the frame is the k-th bit on the wire.
    function automatic logic tx_bit(input logic [LEN0-1:0] d, input int k);
`ifdef SPI_BYTE_MASTER_LSB_FIRST_EN
        return d[k];
`else
        return d[LEN0-1-k];
`endif
    endfunction

    function automatic logic [LEN0-1:0] model_resp(input logic [LEN0-1:0] d, input int m,
                                                   input logic [LEN0-1:0] p);
        logic [LEN0-1:0] r;
        logic b;
        r = '0;
        for (int k = 0; k < LEN0; k++) begin
            if (m == 0)      b = tx_bit(d, k);
            else if (m == 1) b = (k < 8) ? 1'b0 : tx_bit(d, k - 8);
            else             b = p[k];
`ifdef SPI_BYTE_MASTER_LSB_FIRST_EN
            r[k] = b;
`else
            r[LEN0-1-k] = b;
`endif
        end
        return r;
    endfunction

    function automatic logic [7:0] slave_exp(input logic [LEN0-1:0] d);
        logic [7:0] r;
        r = '0;
        for (int k = 0; k < 8; k++) r[7-k] = tx_bit(d, k);
        return r;
    endfunction

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    // Monitor: queues expectations at acceptance, plays the SPI slave, checks responses.
    initial begin : monitor
        exp_t e;
        logic prev_sck;
        prev_sck = 1'b0;
        forever begin
            @(negedge clock);
            if (started && !reset) begin
                if (bus0.req_valid && bus0.req_ready) begin
                    e.data = model_resp(bus0.req_data, mode, plan);
                    e.acc  = cyc + 1;
                    exp_q.push_back(e);
                    rise_cnt      = 0;
                    slave_byte    = '0;
                    first_bit_exp = tx_bit(bus0.req_data, 0);
                end
                if (bus0.sck && !prev_sck) begin
                    check("sck_rise_ss_low", 64'(bus0.ss), 64'(0));
                    if (rise_cnt == 0) check("first_rise_mosi", 64'(bus0.mosi), 64'(first_bit_exp));
                    if (mode == 1) begin
                        if (rise_cnt < 8) slave_byte = {slave_byte[6:0], bus0.mosi};
                        miso_drv = (rise_cnt >= 8) ? slave_byte[15-rise_cnt] : 1'b0;
                    end else if (mode == 2) begin
                        miso_drv = plan[rise_cnt];
                    end
                    rise_cnt++;
                end
                if (bus0.resp_valid) begin
                    n_resp++;
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_resp_valid: got resp_valid=1, expected no pending frame");
                    end else begin
                        e = exp_q.pop_front();
                        check("resp_data", 64'(bus0.resp_data), 64'(e.data));
                        check("resp_cycle", 64'(cyc - e.acc + 1), 64'(RESP_CYC0));
                        check("sck_rises", 64'(rise_cnt), 64'(LEN0));
                    end
                end
            end
            prev_sck = bus0.sck;
        end
    end

    task automatic wait_accept(input string name);
        int t;
        t = 0;
        do begin
            @(negedge clock);
            t++;
        end while (!(bus0.req_valid && bus0.req_ready) && t < 50);
        if (t >= 50) timeout(name);
        @(posedge clock);
        #1 bus0.req_valid = 1'b0;
    endtask

    task automatic wait_resp(input int r0, input string name);
        int t;
        t = 0;
        while (n_resp == r0 && t < 400) begin
            @(negedge clock);
            t++;
        end
        if (t >= 400) timeout(name);
    endtask

    task automatic do_frame(input logic [LEN0-1:0] d, input int m);
        int r0;
        @(posedge clock);
        #1;
        mode = m;
        r0 = n_resp;
        bus0.req_data  = d;
        bus0.req_valid = 1'b1;
        wait_accept("frame_accept");
        wait_resp(r0, "frame_resp");
        @(negedge clock);
        @(negedge clock);
        check("idle_ss", 64'(bus0.ss), 64'(1));
        check("idle_sck", 64'(bus0.sck), 64'(0));
        check("idle_mosi", 64'(bus0.mosi), 64'(1));
        check("idle_ready", 64'(bus0.req_ready), 64'(1));
    endtask

    task automatic dut1_frame();
        int acc, t, last_rise, rises;
        logic prev, got;
        @(posedge clock);
        #1;
        bus1.req_data  = 8'($urandom);
        bus1.req_valid = 1'b1;
        @(negedge clock);
        check("dut1_ready", 64'(bus1.req_ready), 64'(1));
        acc = cyc + 1;
        @(posedge clock);
        #1 bus1.req_valid = 1'b0;
        prev = 1'b0; got = 1'b0; rises = 0; last_rise = -1; t = 0;
        while (!got && t < 100) begin
            @(negedge clock);
            t++;
            if (bus1.sck && !prev) begin
                if (last_rise >= 0) check("dut1_sck_period", 64'(cyc - last_rise), 64'(2));
                last_rise = cyc;
                rises++;
            end
            prev = bus1.sck;
            if (bus1.resp_valid) begin
                got = 1'b1;
                check("dut1_resp_data", 64'(bus1.resp_data), 64'(8'hFF));
                check("dut1_resp_cycle", 64'(cyc - acc + 1), 64'(RESP_CYC1));
                check("dut1_sck_rises", 64'(rises), 64'(LEN1));
            end
        end
        if (!got) timeout("dut1_resp");
    endtask

    task automatic back_to_back();
        logic [LEN0-1:0] d1;
        int acc1, acc2, t, r0;
        d1 = 16'($urandom);
        @(posedge clock);
        #1;
        mode = 0;
        bus0.req_data  = d1;
        bus0.req_valid = 1'b1;
        t = 0;
        do begin
            @(negedge clock);
            t++;
        end while (!(bus0.req_valid && bus0.req_ready) && t < 50);
        acc1 = cyc + 1;
        @(posedge clock);
        #1 bus0.req_data = ~d1;
        t = 0;
        do begin
            @(negedge clock);
            t++;
        end while (!bus0.resp_valid && t < 400);
        if (t >= 400) timeout("b2b_first_resp");
        check("b2b_ss_done", 64'(bus0.ss), 64'(1));
        check("b2b_ready_done", 64'(bus0.req_ready), 64'(0));
        @(negedge clock);
        check("b2b_ss_gap", 64'(bus0.ss), 64'(1));
        check("b2b_ready_gap", 64'(bus0.req_ready), 64'(1));
        acc2 = cyc + 1;
        check("b2b_period", 64'(acc2 - acc1), 64'(PERIOD0));
        r0 = n_resp;
        @(posedge clock);
        #1 bus0.req_valid = 1'b0;
        @(negedge clock);
        check("b2b_ss_fall", 64'(bus0.ss), 64'(0));
        wait_resp(r0, "b2b_second_resp");
        @(negedge clock);
    endtask

    task automatic abort_frame();
        int t, r0;
        @(posedge clock);
        #1;
        mode = 0;
        bus0.req_data  = 16'($urandom);
        bus0.req_valid = 1'b1;
        wait_accept("abort_accept");
        t = 0;
        while (rise_cnt < 5 && t < 200) begin
            @(negedge clock);
            t++;
        end
        if (t >= 200) timeout("abort_rise5");
        #3 reset = 1'b1;
        exp_q.delete();
        r0 = n_resp;
        #1;
        check("abort_ss", 64'(bus0.ss), 64'(1));
        check("abort_sck", 64'(bus0.sck), 64'(0));
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        repeat (200) @(negedge clock);
        check("abort_no_resp", 64'(n_resp), 64'(r0));
        do_frame(16'h0001, 0);
    endtask

    initial begin
        bus0.req_valid = 1'b0;
        bus0.req_data  = '0;
        bus1.req_valid = 1'b0;
        bus1.req_data  = '0;

        #12 reset = 1'b1;
        #1;
        check("rst_ss", 64'(bus0.ss), 64'(1));
        check("rst_sck", 64'(bus0.sck), 64'(0));
        check("rst_mosi", 64'(bus0.mosi), 64'(1));
        check("rst_ready", 64'(bus0.req_ready), 64'(1));
        check("rst_resp_valid", 64'(bus0.resp_valid), 64'(0));
        check("rst_resp_data", 64'(bus0.resp_data), 64'(0));
        check("rst_dut1_ss", 64'(bus1.ss), 64'(1));
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        started = 1'b1;
        repeat (3) @(negedge clock);
        check("post_rst_ss", 64'(bus0.ss), 64'(1));
        check("post_rst_sck", 64'(bus0.sck), 64'(0));
        check("post_rst_mosi", 64'(bus0.mosi), 64'(1));
        check("post_rst_ready", 64'(bus0.req_ready), 64'(1));
        check("post_rst_resp_valid", 64'(bus0.resp_valid), 64'(0));

        do_frame(16'hA5C3, 0);
        do_frame(16'h5A00, 1);
        check("slave_log", 64'(slave_byte), 64'(slave_exp(16'h5A00)));
        for (int i = 0; i < 3; i++) do_frame(16'($urandom), 0);
        for (int i = 0; i < 4; i++) begin
            plan = 16'($urandom);
            do_frame(16'($urandom), 2);
        end
        dut1_frame();
        back_to_back();
        abort_frame();
        check("queue_drained", 64'(exp_q.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
